// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer and its users.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STAGGER = 2'd1,
        RUN     = 2'd2
    } reset_state_e;

    // Counter must hold the larger of the two terminal counts without wrapping.
    function automatic int cnt_width(input int stretch, input int stagger);
        int m;
        m = (stretch > stagger) ? stretch : stagger;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/reset bundle between requesters and the sequencer, plus FSM state for observers.
interface reset_sequencer_if #(
    parameter int NUM_CHANNELS = 4
);
    import reset_seq_pkg::*;

    // req is level-sampled on every rising clk edge; there is no handshake.
    // rst_out/busy/state are registered outputs valid after each edge.
    logic [NUM_CHANNELS-1:0] req;
    logic [NUM_CHANNELS-1:0] rst_out;
    logic                    busy;
    reset_state_e            state;

    modport master (
        output req,
        input  rst_out,
        input  busy,
        input  state
    );

    modport slave (
        input  req,
        output rst_out,
        output busy,
        output state
    );

endinterface

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second clock edge.
module reset_sync (
    input  logic clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign o_rst_n = r_sync[1];

endmodule

// File: rtl/reset_sequencer.sv
// Stretches reset requests into a hold window, then releases channels in index order.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int STRETCH_CYCLES = 8,
    parameter int STAGGER_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    reset_sequencer_if.slave bus
);

    localparam int CNT_W = cnt_width(STRETCH_CYCLES, STAGGER_CYCLES);
    localparam int IDX_W = $clog2(NUM_CHANNELS + 1);

    localparam logic [CNT_W-1:0] STRETCH_TERM = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_TERM =
        CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHANNELS - 1);
    localparam bit DIRECT_RUN = (NUM_CHANNELS == 1) || (STAGGER_CYCLES == 0);

    logic                    w_sync_rst_n;
    logic                    w_req_any;
    logic                    r_cnt_en;
    reset_state_e            r_state;
    reset_state_e            w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [NUM_CHANNELS-1:0] r_rst;
    logic [NUM_CHANNELS-1:0] w_rst_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;

    reset_sync u_reset_sync (
        .clk     (clk),
        .i_rst_n (reset),
        .o_rst_n (w_sync_rst_n)
    );

    assign w_req_any = |bus.req;
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // r_cnt_en lags the synchronizer by one edge so power-up gets the same hold as a request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_en <= 1'b0;
            r_state  <= HOLD;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_rst    <= '1;
            r_busy   <= 1'b1;
        end else begin
            r_cnt_en <= w_sync_rst_n;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_rst    <= w_rst_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_rst;

        if (w_req_any || !r_cnt_en) begin
            // A request beats a same-edge terminal count.
            w_state_nxt = HOLD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_rst_nxt   = '1;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == STRETCH_TERM) begin
                        w_cnt_nxt = '0;
                        if (DIRECT_RUN) begin
                            w_rst_nxt   = '0;
                            w_state_nxt = RUN;
                        end else begin
                            w_rst_nxt[0] = 1'b0;
                            w_idx_nxt    = IDX_W'(1);
                            w_state_nxt  = STAGGER;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                STAGGER: begin
                    if (r_cnt == STAGGER_TERM) begin
                        w_cnt_nxt = '0;
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            if (i == int'(r_idx)) begin
                                w_rst_nxt[i] = 1'b0;
                            end
                        end
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                RUN: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_nxt   = '1;
                end
            endcase
        end

        w_busy_nxt = |w_rst_nxt;
    end

    assign bus.rst_out = r_rst;
    assign bus.busy    = r_busy;
    assign bus.state   = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: two sequencers (stagger 3 and stagger 0) share clock and reset.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int EW = 23;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int cyc = -1;
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [EW-1:0] exp1_q[$];
  logic [EW-1:0] exp0_q[$];

  reset_sequencer_if #(.NUM_CHANNELS(4)) bus1();
  reset_sequencer_if #(.NUM_CHANNELS(4)) bus0();

  reset_sequencer #(.NUM_CHANNELS(4), .STRETCH_CYCLES(8), .STAGGER_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset_n), .bus(bus1)
  );
  reset_sequencer #(.NUM_CHANNELS(4), .STRETCH_CYCLES(8), .STAGGER_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset_n), .bus(bus0)
  );

  // clock / reset-relative edge counter: edge 0 is the first edge that samples reset high
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset_n ? cyc + 1 : -1;

  function automatic logic [EW-1:0] ev(input int c, input reset_state_e s, input logic b,
                                       input logic [3:0] r);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, logic'(s[1]), logic'(s[0]), b, r};
  endfunction

  task automatic check_ev(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got cyc=%0d st=%0d busy=%b rst=%b, required cyc=%0d st=%0d busy=%b rst=%b",
               name, act[22:7], act[6:5], act[4], act[3:0], exp[22:7], exp[6:5], exp[4], exp[3:0]);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic to_edge(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cyc != n && k < 1000);
    if (cyc != n) begin
      n_vec++;
      n_err++;
      $display("FAIL to_edge: cyc=%0d, required %0d", cyc, n);
    end
  endtask

  task automatic push_powerup();
    exp1_q.push_back(ev(10, STAGGER, 1'b1, 4'b1110));
    exp1_q.push_back(ev(13, STAGGER, 1'b1, 4'b1100));
    exp1_q.push_back(ev(16, STAGGER, 1'b1, 4'b1000));
    exp1_q.push_back(ev(19, RUN,     1'b0, 4'b0000));
    exp0_q.push_back(ev(10, RUN,     1'b0, 4'b0000));
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_rst1"},  {4'h0, bus1.rst_out}, 8'h0F);
    check_val({tag, "_busy1"}, {7'h0, bus1.busy}, 8'h01);
    check_val({tag, "_st1"},   {6'h0, bus1.state}, 8'h00);
    check_val({tag, "_rst0"},  {4'h0, bus0.rst_out}, 8'h0F);
    check_val({tag, "_busy0"}, {7'h0, bus0.busy}, 8'h01);
  endtask

  // monitor: every change of {busy, rst_out} pops one expected event
  initial begin
    logic [4:0] prev1, prev0, cur1, cur0;
    logic [15:0] c16;
    prev1 = 5'h1F;
    prev0 = 5'h1F;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        c16 = cyc[15:0];
        cur1 = {bus1.busy, bus1.rst_out};
        cur0 = {bus0.busy, bus0.rst_out};
        if (cur1 != prev1) begin
          prev1 = cur1;
          if (exp1_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL dut1_unexpected: cyc=%0d busy/rst=%b, required no change", cyc, cur1);
          end else begin
            check_ev("dut1_event", {c16, bus1.state, cur1}, exp1_q.pop_front());
          end
        end
        if (cur0 != prev0) begin
          prev0 = cur0;
          if (exp0_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL dut0_unexpected: cyc=%0d busy/rst=%b, required no change", cyc, cur0);
          end else begin
            check_ev("dut0_event", {c16, bus0.state, cur0}, exp0_q.pop_front());
          end
        end
      end
    end
  end

  // driver
  initial begin
    bus1.req = '0;
    bus0.req = '0;
    #2 reset_n = 1'b0;
    #1 check_reset_state("por");
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("por_sync_window");
    push_powerup();
    reset_n = 1'b1;

    fork
      begin
        exp1_q.push_back(ev(30, HOLD,    1'b1, 4'b1111));
        exp1_q.push_back(ev(38, STAGGER, 1'b1, 4'b1110));
        exp1_q.push_back(ev(41, STAGGER, 1'b1, 4'b1100));
        exp1_q.push_back(ev(44, STAGGER, 1'b1, 4'b1000));
        exp1_q.push_back(ev(47, RUN,     1'b0, 4'b0000));
        to_edge(29); bus1.req = 4'b0010; to_edge(30); bus1.req = '0;

        exp1_q.push_back(ev(50, HOLD,    1'b1, 4'b1111));
        exp1_q.push_back(ev(58, STAGGER, 1'b1, 4'b1110));
        to_edge(49); bus1.req = 4'b1000; to_edge(50); bus1.req = '0;

        exp1_q.push_back(ev(60, HOLD,    1'b1, 4'b1111));
        to_edge(59); bus1.req = 4'b0100; to_edge(60); bus1.req = '0;

        exp1_q.push_back(ev(91,  STAGGER, 1'b1, 4'b1110));
        exp1_q.push_back(ev(94,  STAGGER, 1'b1, 4'b1100));
        exp1_q.push_back(ev(97,  STAGGER, 1'b1, 4'b1000));
        exp1_q.push_back(ev(100, RUN,     1'b0, 4'b0000));
        to_edge(63); bus1.req = 4'b1111; to_edge(83); bus1.req = '0;

        exp1_q.push_back(ev(110, HOLD,    1'b1, 4'b1111));
        exp1_q.push_back(ev(126, STAGGER, 1'b1, 4'b1110));
        exp1_q.push_back(ev(129, STAGGER, 1'b1, 4'b1100));
        exp1_q.push_back(ev(132, STAGGER, 1'b1, 4'b1000));
        exp1_q.push_back(ev(135, RUN,     1'b0, 4'b0000));
        to_edge(109); bus1.req = 4'b0001; to_edge(110); bus1.req = '0;
        to_edge(117); bus1.req = 4'b0001; to_edge(118); bus1.req = '0;
      end
      begin
        exp0_q.push_back(ev(20, HOLD, 1'b1, 4'b1111));
        exp0_q.push_back(ev(28, RUN,  1'b0, 4'b0000));
        to_edge(19); bus0.req = 4'b0001; to_edge(20); bus0.req = '0;

        exp0_q.push_back(ev(40, HOLD, 1'b1, 4'b1111));
        exp0_q.push_back(ev(56, RUN,  1'b0, 4'b0000));
        to_edge(39); bus0.req = 4'b0110; to_edge(40); bus0.req = '0;
        to_edge(47); bus0.req = 4'b1000; to_edge(48); bus0.req = '0;
      end
    join

    exp1_q.push_back(ev(141, HOLD, 1'b1, 4'b1111));
    exp0_q.push_back(ev(141, HOLD, 1'b1, 4'b1111));
    to_edge(140);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_state("async_reset");
    repeat (3) @(negedge clk);
    push_powerup();
    reset_n = 1'b1;
    to_edge(30);

    n_vec++;
    if (exp1_q.size() != 0) begin
      n_err++;
      $display("FAIL dut1_queue_empty: %0d events pending, required 0", exp1_q.size());
    end
    n_vec++;
    if (exp0_q.size() != 0) begin
      n_err++;
      $display("FAIL dut0_queue_empty: %0d events pending, required 0", exp0_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
